// File: rtl/data_mem_ctrl.sv
// Purpose: byte/halfword/word data memory with request handshake and fault response.
// Latency: loads respond READ_LAT cycles after accept; stores and faults respond after 1 cycle.
// Backpressure: ready is high only in IDLE; a req seen while ready=0 is dropped, not queued.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   req / ready      request valid / controller idle and able to accept
//   we, size, A, WD  request fields, captured on accept (size 00=B, 01=H, 10=W, 11=reserved)
//   resp_valid       one-cycle response pulse for every accepted request
//   resp_fault       qualifies resp_valid: request was rejected (alignment, range, size)
//   ReadData         zero-extended load result; zero outside the response cycle
module data_mem_ctrl #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] ReadData
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // BUSY covers READ_LAT-1 cycles; the counter runs down from READ_LAT-2 to 0.
  localparam logic [1:0] BUSY_INIT = 2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("data_mem_ctrl: READ_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] ld_pipe_q [READ_LAT];

  // Storage powers up zeroed and is deliberately left out of the reset domain.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic                  accept;
  logic                  fault_c;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic [31:0]           rword;
  logic [31:0]           load_d;
  logic [3:0]            be;
  logic [31:0]           wlanes;

  assign ready  = (state_q == IDLE);
  assign accept = req & ready;
  assign idx    = A[DEPTH_LOG2+1:2];
  assign off    = A[1:0];
  assign rword  = mem_q[idx];

  // Fault checks use the live inputs, which are exactly the values captured at accept.
  always_comb begin
    fault_c = 1'b0;
    case (size)
      2'b00:   fault_c = 1'b0;
      2'b01:   fault_c = A[0];
      2'b10:   fault_c = (A[1:0] != 2'b00);
      default: fault_c = 1'b1;
    endcase
    if ((A >> (DEPTH_LOG2 + 2)) != 32'd0) begin
      fault_c = 1'b1;
    end
  end

  // Load extraction by byte offset, zero-extended.
  always_comb begin
    load_d = 32'd0;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    load_d = {24'd0, rword[7:0]};
          2'd1:    load_d = {24'd0, rword[15:8]};
          2'd2:    load_d = {24'd0, rword[23:16]};
          default: load_d = {24'd0, rword[31:24]};
        endcase
      end
      2'b01:   load_d = off[1] ? {16'd0, rword[31:16]} : {16'd0, rword[15:0]};
      default: load_d = rword;
    endcase
  end

  // Store lane enables; data is replicated so every enabled lane sees the right bits.
  always_comb begin
    be     = 4'b0000;
    wlanes = WD;
    case (size)
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{WD[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{WD[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = WD;
      end
    endcase
  end

  // Stores commit at the accept edge, so a later load always sees them.
  always_ff @(posedge clk) begin
    if (accept && we && !fault_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
    end
  end

  // Load data pipeline. Only a valid load injects non-zero data, and at most one
  // request is in flight, so the last stage is non-zero only during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        ld_pipe_q[i] <= 32'd0;
      end
    end else begin
      ld_pipe_q[0] <= (accept && !we && !fault_c) ? load_d : 32'd0;
      for (int i = 1; i < READ_LAT; i++) begin
        ld_pipe_q[i] <= ld_pipe_q[i-1];
      end
    end
  end

  // Control FSM with registered response flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          if (accept) begin
            if (we || fault_c || (READ_LAT == 1)) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= fault_c;
            end else begin
              state_q <= BUSY;
              cnt_q   <= BUSY_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 2'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign ReadData   = ld_pipe_q[READ_LAT-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Purpose: directed bench for data_mem_ctrl with READ_LAT=1 and READ_LAT=3 instances.
// Latency: checks exact response cycle of every request.
// Backpressure: checks ready pattern and that busy-time requests are dropped.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req1 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] A = 32'd0;
  logic [31:0] WD = 32'd0;
  logic        ready1, rv1, rf1;
  logic        ready3, rv3, rf3;
  logic [31:0] rd1, rd3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_LOG2(8), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .ready(ready1), .we(we), .size(size),
    .A(A), .WD(WD), .resp_valid(rv1), .resp_fault(rf1), .ReadData(rd1)
  );

  data_mem_ctrl #(.DEPTH_LOG2(8), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .ready(ready3), .we(we), .size(size),
    .A(A), .WD(WD), .resp_valid(rv3), .resp_fault(rf3), .ReadData(rd3)
  );

  typedef struct {
    bit          d3;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          flt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request and check response latency, fault flag, data and pulse width.
  task automatic issue(input bit d3, input logic iwe, input logic [1:0] isz,
                       input logic [31:0] ia, input logic [31:0] iwd,
                       input logic [31:0] exp_rd, input bit exp_flt, input string nm);
    int   lat;
    int   exp_lat;
    bit   got;
    logic got_f;
    logic [31:0] got_d;
    for (int k = 0; k < 10 && !(d3 ? ready3 : ready1); k++) @(negedge clk);
    chk({nm, " ready"}, 32'(d3 ? ready3 : ready1), 32'd1);
    we = iwe; size = isz; A = ia; WD = iwd;
    if (d3) req3 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0; req3 = 1'b0;
    got = 1'b0; lat = 0; got_f = 1'b0; got_d = 32'd0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (d3 ? rv3 : rv1) begin
        got = 1'b1; lat = c;
        got_f = d3 ? rf3 : rf1;
        got_d = d3 ? rd3 : rd1;
      end
    end
    exp_lat = (!iwe && !exp_flt) ? (d3 ? 3 : 1) : 1;
    chk({nm, " lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, " fault"}, 32'(got_f), 32'(exp_flt));
    chk({nm, " data"}, got_d, exp_rd);
    @(negedge clk);
    chk({nm, " pulse"}, {31'd0, d3 ? rv3 : rv1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   cnt;

    // d3, we, size, addr, wd, expected data, expected fault
    tbl.push_back('{0, 1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{0, 0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 2'b10, 32'h20,  32'h11223344, 32'h0,        0});
    tbl.push_back('{0, 1, 2'b00, 32'h21,  32'h000000AB, 32'h0,        0});
    tbl.push_back('{0, 0, 2'b10, 32'h20,  32'h0,        32'h1122AB44, 0});
    tbl.push_back('{0, 0, 2'b00, 32'h21,  32'h0,        32'h000000AB, 0});
    tbl.push_back('{0, 0, 2'b00, 32'h23,  32'h0,        32'h00000011, 0});
    tbl.push_back('{0, 0, 2'b01, 32'h20,  32'h0,        32'h0000AB44, 0});
    tbl.push_back('{0, 1, 2'b01, 32'h32,  32'h0000CAFE, 32'h0,        0});
    tbl.push_back('{0, 0, 2'b01, 32'h32,  32'h0,        32'h0000CAFE, 0});
    tbl.push_back('{0, 0, 2'b10, 32'h30,  32'h0,        32'hCAFE0000, 0});
    tbl.push_back('{0, 0, 2'b10, 32'h41,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 2'b10, 32'h0,   32'h55AA55AA, 32'h0,        0});
    tbl.push_back('{0, 1, 2'b10, 32'h400, 32'hFFFFFFFF, 32'h0,        1});
    tbl.push_back('{0, 0, 2'b10, 32'h0,   32'h0,        32'h55AA55AA, 0});
    tbl.push_back('{0, 0, 2'b11, 32'h0,   32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 2'b11, 32'h0,   32'h0,        32'h0,        1});
    tbl.push_back('{0, 0, 2'b10, 32'h0,   32'h0,        32'h55AA55AA, 0});
    tbl.push_back('{0, 0, 2'b01, 32'h31,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 2'b10, 32'h3FC, 32'h12345678, 32'h0,        0});
    tbl.push_back('{0, 1, 2'b00, 32'h3FF, 32'hFFFFFF9A, 32'h0,        0});
    tbl.push_back('{0, 0, 2'b10, 32'h3FC, 32'h0,        32'h9A345678, 0});
    tbl.push_back('{0, 1, 2'b01, 32'h3FC, 32'hFFFF0001, 32'h0,        0});
    tbl.push_back('{0, 0, 2'b10, 32'h3FC, 32'h0,        32'h9A340001, 0});
    tbl.push_back('{0, 0, 2'b00, 32'h80000000, 32'h0,   32'h0,        1});
    tbl.push_back('{1, 1, 2'b10, 32'h10,  32'h0BADF00D, 32'h0,        0});
    tbl.push_back('{1, 0, 2'b10, 32'h10,  32'h0,        32'h0BADF00D, 0});
    tbl.push_back('{1, 0, 2'b00, 32'h11,  32'h0,        32'h000000F0, 0});
    tbl.push_back('{1, 0, 2'b01, 32'h12,  32'h0,        32'h00000BAD, 0});
    tbl.push_back('{1, 0, 2'b10, 32'h42,  32'h0,        32'h0,        1});
    tbl.push_back('{1, 1, 2'b00, 32'h13,  32'h00000077, 32'h0,        0});
    tbl.push_back('{1, 0, 2'b10, 32'h10,  32'h0,        32'h77ADF00D, 0});

    // Reset state.
    #12;
    chk("rst ready1", {31'd0, ready1}, 32'd1);
    chk("rst rv1",    {31'd0, rv1},    32'd0);
    chk("rst rf1",    {31'd0, rf1},    32'd0);
    chk("rst rd1",    rd1,             32'd0);
    chk("rst ready3", {31'd0, ready3}, 32'd1);
    chk("rst rv3",    {31'd0, rv3},    32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i].d3, tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd,
            tbl[i].rd, tbl[i].flt, $sformatf("v%0d", i));
    end

    // READ_LAT=3 with req held high: ready 1,0,0,0,1; busy-time req dropped.
    chk("hold c0 ready", {31'd0, ready3}, 32'd1);
    we = 1'b0; size = 2'b10; A = 32'h10; req3 = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h44;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d ready", c), {31'd0, ready3}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("hold c%0d rv", c),    {31'd0, rv3},    (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) chk("hold c3 data", rd3, 32'h77ADF00D);
    end
    req3 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv3) cnt++;
    end
    chk("hold no extra resp", 32'(cnt), 32'd0);

    // Reset one cycle after a READ_LAT=3 load accept.
    issue(1, 1'b1, 2'b10, 32'h50, 32'hA5A5A5A5, 32'h0, 1'b0, "rs store");
    we = 1'b0; size = 2'b10; A = 32'h50; req3 = 1'b1;
    @(posedge clk);
    #1;
    req3 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs ready3", {31'd0, ready3}, 32'd1);
    chk("rs rv3",    {31'd0, rv3},    32'd0);
    chk("rs rd3",    rd3,             32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv3) cnt++;
    end
    chk("rs discarded", 32'(cnt), 32'd0);
    issue(1, 1'b0, 2'b10, 32'h50, 32'h0, 32'hA5A5A5A5, 1'b0, "rs keep3");
    issue(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rs keep1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised next-generation data memory for the ARM datapath, replacing the fixed single-cycle word RAM.
- Adds byte, halfword and word accesses with lane-correct stores and zero-extended loads.
- Adds a req/ready request handshake, a configurable read latency, a response pulse, and a fault response for misaligned or out-of-range addresses.
- Sits between the datapath (or a future multicycle control FSM) and on-chip RAM storage.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words; word index = A[DEPTH_LOG2+1:2].
- READ_LAT, 1, cycles from read accept to response; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- ready  out  1  controller can accept a request this cycle.
- we  in  1  1 = store, 0 = load; sampled on accept.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (faults); sampled on accept.
- A  in  32  byte address; sampled on accept.
- WD  in  32  store data, right-aligned (byte in WD[7:0], halfword in WD[15:0]); sampled on accept.
- resp_valid  out  1  one-cycle response pulse, for both loads and stores.
- resp_fault  out  1  qualifies resp_valid; 1 = request rejected.
- ReadData  out  32  load result, valid while resp_valid=1 and resp_fault=0.

Behaviour:
- Accept occurs at a rising edge where req=1 and ready=1. we, size, A and WD are captured at that edge.
- States:
  - IDLE: ready=1.
  - BUSY: counter running; ready=0.
  - RESP: resp_valid=1; ready=0.
  - After RESP, always return to IDLE. Ready is a decode of state and is never combinationally dependent on req.
- Response cycle:
  - Valid load: resp_valid is high in the cycle beginning READ_LAT edges after accept. When READ_LAT=1, go directly IDLE->RESP.
  - Store or fault: resp_valid is high in the cycle beginning 1 edge after accept.
  - The earliest next accept is the edge ending the RESP cycle. Word throughput is 1 request per READ_LAT+1 cycles.
- req while ready=0 is ignored, not queued.
- Fault conditions, evaluated on the captured request:
  - size=11.
  - size=10 with A[1:0]!=0.
  - size=01 with A[0]!=0.
  - Any A[31:DEPTH_LOG2+2] nonzero.
- On fault: RAM unchanged, resp_fault=1, ReadData=0.
- Stores:
  - RAM is updated at the accept edge.
  - Byte: lane A[1:0] gets WD[7:0].
  - Halfword: lane pair A[1] gets WD[15:0].
  - Word: full word.
  - Other lanes are preserved.
- Loads:
  - RAM is read from the captured index. Data is registered and held in a pipeline of READ_LAT stages.
  - Byte and halfword results are extracted by the captured A[1:0] and zero-extended to 32 bits.
  - A load following a store to the same word returns the post-store value.
- Outputs outside RESP: resp_valid=0, resp_fault=0, ReadData=0.
- RAM contents:
  - Initialised to all zeros at time 0.
  - NOT cleared by reset.
- Reset (asynchronous, any state):
  - State -> IDLE; ready=1; resp_valid=0, resp_fault=0, ReadData=0; counter=0.
  - An in-flight load's response is discarded.
  - A store already accepted remains committed.
- A synthesis-time check (or simulation $error) is required if READ_LAT is outside 1..4.

Test Plan:
- Word store A=0x10, WD=0xDEADBEEF, then word load A=0x10 (READ_LAT=1) -> store resp_valid 1 cycle after accept with fault=0; load ReadData=0xDEADBEEF 1 cycle after accept.
- Byte store A=0x21, WD=0x000000AB over word 0x11223344, then word load A=0x20 -> 0x1122AB44. Byte load A=0x21 -> 0x000000AB.
- Halfword store A=0x32, WD=0x0000CAFE over 0, then halfword load A=0x32 -> 0x0000CAFE. Word load A=0x30 -> 0xCAFE0000.
- Faults with DEPTH_LOG2=8:
  - Word load A=0x41 -> resp_fault=1, ReadData=0.
  - Word store A=0x400 -> resp_fault=1 and word 0 unchanged.
  - size=11 -> resp_fault=1.
- READ_LAT=3 with req held high continuously -> ready pattern 1,0,0,0,1. resp_valid in the 3rd cycle after accept. Requests during busy are not accepted.
- Reset pulse 1 cycle after a READ_LAT=3 load accept -> no resp_valid ever appears. ready=1 immediately. A prior store's data survives the reset.
